// File: rtl/interval_timer_ctl.sv
// Interval timer: prescaled up/down counter with run/pause/done control and a hex 7-segment view of the count.
// Latency: count/status registered; seg combinational from count; timeout one cycle after the terminal step.
// Backpressure: none; start/stop/clr are single-cycle pulses, priority clr > stop > start.
module interval_timer_ctl #(
    parameter int TICK_DIV    = 50000,
    parameter int CNT_W       = 4,
    parameter bit SEG_ACT_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clr,
    input  logic             dir,
    input  logic             reload_en,
    input  logic [CNT_W-1:0] interval,
    output logic [CNT_W-1:0] count,
    output logic [6:0]       seg,
    output logic             running,
    output logic             paused,
    output logic             done,
    output logic             timeout
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int NW = (CNT_W < 4) ? CNT_W : 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic [PW-1:0]    pre;
    logic             dir_q;
    logic             rel_q;
    logic [CNT_W-1:0] ival_q;
    logic             pend;

    logic             tick;
    logic [CNT_W-1:0] term_val;
    logic [CNT_W-1:0] start_val;
    logic [CNT_W-1:0] nxt;

    assign tick      = (state == S_RUN) && (pre == PW'(TICK_DIV - 1));
    assign term_val  = dir_q ? '0 : ival_q;
    assign start_val = dir_q ? ival_q : '0;
    assign nxt       = dir_q ? (count - 1'b1) : (count + 1'b1);

    // pend marks the edge that reached terminal; timeout follows it by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            pre     <= '0;
            count   <= '0;
            dir_q   <= 1'b0;
            rel_q   <= 1'b0;
            ival_q  <= '0;
            pend    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            timeout <= pend;
            pend    <= 1'b0;
            if (clr) begin
                state   <= S_IDLE;
                pre     <= '0;
                count   <= '0;
                timeout <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            dir_q  <= dir;
                            rel_q  <= reload_en;
                            ival_q <= interval;
                            count  <= dir ? interval : '0;
                            pre    <= '0;
                            state  <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (stop) begin
                            state <= S_PAUSE;
                        end else if (ival_q == '0) begin
                            // degenerate interval: finish at once, reload is meaningless
                            state   <= S_DONE;
                            pre     <= '0;
                            timeout <= 1'b1;
                        end else if (tick) begin
                            pre <= '0;
                            if (count == term_val) begin
                                count <= start_val;
                            end else begin
                                count <= nxt;
                                if (nxt == term_val) begin
                                    pend <= 1'b1;
                                    if (!rel_q) state <= S_DONE;
                                end
                            end
                        end else begin
                            pre <= pre + 1'b1;
                        end
                    end
                    S_PAUSE: begin
                        if (start) state <= S_RUN;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign running = (state == S_RUN);
    assign paused  = (state == S_PAUSE);
    assign done    = (state == S_DONE);

    logic [3:0] nib;
    logic [6:0] raw;

    assign nib = 4'(count[NW-1:0]);

    always_comb begin
        raw = 7'h00;
        case (nib)
            4'h0: raw = 7'h3F;
            4'h1: raw = 7'h06;
            4'h2: raw = 7'h5B;
            4'h3: raw = 7'h4F;
            4'h4: raw = 7'h66;
            4'h5: raw = 7'h6D;
            4'h6: raw = 7'h7D;
            4'h7: raw = 7'h07;
            4'h8: raw = 7'h7F;
            4'h9: raw = 7'h6F;
            4'hA: raw = 7'h77;
            4'hB: raw = 7'h7C;
            4'hC: raw = 7'h39;
            4'hD: raw = 7'h5E;
            4'hE: raw = 7'h79;
            4'hF: raw = 7'h71;
            default: raw = 7'h00;
        endcase
    end

    assign seg = SEG_ACT_LOW ? ~raw : raw;
endmodule

// File: tb/tb_interval_timer_ctl.sv
// Directed bench for interval_timer_ctl: per-cycle expectations queued with the stimulus, checked after each edge.
module tb_interval_timer_ctl;
    logic       clk = 1'b0;
    logic       rst, start, stop, clr, dir, reload_en;
    logic [3:0] interval;

    logic [3:0] count0, count1;
    logic [6:0] seg0, seg1;
    logic       running0, paused0, done0, timeout0;
    logic       running1, paused1, done1, timeout1;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [2:0] ST_IDLE = 3'b000;
    localparam logic [2:0] ST_RUN  = 3'b100;
    localparam logic [2:0] ST_PAU  = 3'b010;
    localparam logic [2:0] ST_DN   = 3'b001;

    typedef struct {
        string      tag;
        logic [3:0] cnt;
        logic [2:0] st;
        logic       to;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    interval_timer_ctl #(.TICK_DIV(4), .CNT_W(4), .SEG_ACT_LOW(1'b0)) u0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr),
        .dir(dir), .reload_en(reload_en), .interval(interval),
        .count(count0), .seg(seg0), .running(running0), .paused(paused0),
        .done(done0), .timeout(timeout0)
    );

    interval_timer_ctl #(.TICK_DIV(4), .CNT_W(4), .SEG_ACT_LOW(1'b1)) u1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr),
        .dir(dir), .reload_en(reload_en), .interval(interval),
        .count(count1), .seg(seg1), .running(running1), .paused(paused1),
        .done(done1), .timeout(timeout1)
    );

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F; 4'h1: hex7 = 7'h06; 4'h2: hex7 = 7'h5B; 4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66; 4'h5: hex7 = 7'h6D; 4'h6: hex7 = 7'h7D; 4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F; 4'h9: hex7 = 7'h6F; 4'hA: hex7 = 7'h77; 4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39; 4'hD: hex7 = 7'h5E; 4'hE: hex7 = 7'h79; default: hex7 = 7'h71;
        endcase
    endfunction

    task automatic chk(input string tag, input string what, input logic [7:0] obs, input logic [7:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, expv);
        end
    endtask

    task automatic push(input string tag, input logic [3:0] c, input logic [2:0] st, input logic to);
        exp_t e;
        e.tag = tag; e.cnt = c; e.st = st; e.to = to;
        sb.push_back(e);
    endtask

    task automatic tick1();
        exp_t e;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk(e.tag, "count",   {4'h0, count0}, {4'h0, e.cnt});
        chk(e.tag, "status",  {5'h0, running0, paused0, done0}, {5'h0, e.st});
        chk(e.tag, "timeout", {7'h0, timeout0}, {7'h0, e.to});
        chk(e.tag, "seg",     {1'b0, seg0}, {1'b0, hex7(e.cnt)});
        chk(e.tag, "seg_al",  {1'b0, seg1}, {1'b0, ~hex7(e.cnt)});
        chk(e.tag, "u1_state", {3'h0, count1, timeout1}, {3'h0, e.cnt, e.to});
    endtask

    task automatic cyc(input string tag, input logic [3:0] c, input logic [2:0] st, input logic to);
        push(tag, c, st, to);
        tick1();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; clr = 1'b0;
        dir = 1'b0; reload_en = 1'b0; interval = 4'h0;
        cyc("reset", 4'h0, ST_IDLE, 1'b0);
        rst = 1'b0;
        cyc("idle", 4'h0, ST_IDLE, 1'b0);

        // down 3 -> 0, single shot
        dir = 1'b1; interval = 4'h3; reload_en = 1'b0;
        for (int v = 3; v >= 1; v--) begin
            for (int k = 0; k < 4; k++) begin
                start = (v == 3 && k == 0);
                cyc("down", 4'(v), ST_RUN, 1'b0);
                start = 1'b0;
            end
        end
        cyc("down_term", 4'h0, ST_DN, 1'b0);
        cyc("down_to",   4'h0, ST_DN, 1'b1);
        repeat (6) cyc("down_hold", 4'h0, ST_DN, 1'b0);

        // up 0 -> 5 with reload; live inputs changed and start pulsed mid-run
        dir = 1'b0; interval = 4'h5; reload_en = 1'b1;
        for (int p = 0; p < 2; p++) begin
            for (int v = 0; v <= 5; v++) begin
                for (int k = 0; k < 4; k++) begin
                    start = (p == 0 && v == 0 && k == 0) || (p == 1 && v == 2 && k == 1);
                    if (p == 0 && v == 0 && k == 1) begin
                        interval = 4'h2; dir = 1'b1; reload_en = 1'b0;
                    end
                    cyc("up_reload", 4'(v), ST_RUN, (v == 5 && k == 1));
                    start = 1'b0;
                end
            end
        end

        // pause 3 cycles after a step, resume two cycles before the next step
        cyc("reload_step", 4'h0, ST_RUN, 1'b0);
        cyc("pre1", 4'h0, ST_RUN, 1'b0);
        cyc("pre2", 4'h0, ST_RUN, 1'b0);
        stop = 1'b1;
        cyc("stop", 4'h0, ST_PAU, 1'b0);
        stop = 1'b0;
        repeat (10) cyc("paused", 4'h0, ST_PAU, 1'b0);
        start = 1'b1;
        cyc("resume", 4'h0, ST_RUN, 1'b0);
        start = 1'b0;
        cyc("resume1", 4'h0, ST_RUN, 1'b0);
        cyc("resume_step", 4'h1, ST_RUN, 1'b0);

        // stop on the tick edge discards the tick
        repeat (3) cyc("run1", 4'h1, ST_RUN, 1'b0);
        stop = 1'b1;
        cyc("stop_tick", 4'h1, ST_PAU, 1'b0);
        stop = 1'b0; start = 1'b1;
        cyc("resume_t", 4'h1, ST_RUN, 1'b0);
        start = 1'b0;
        cyc("held_tick", 4'h2, ST_RUN, 1'b0);

        // priority
        start = 1'b1; stop = 1'b1; clr = 1'b1;
        cyc("all3", 4'h0, ST_IDLE, 1'b0);
        stop = 1'b0; clr = 1'b0;
        cyc("load_live", 4'h2, ST_RUN, 1'b0);
        stop = 1'b1;
        cyc("start_stop", 4'h2, ST_PAU, 1'b0);
        start = 1'b0; stop = 1'b0; clr = 1'b1;
        cyc("clr_pause", 4'h0, ST_IDLE, 1'b0);
        clr = 1'b0;

        // zero interval, reload requested
        interval = 4'h0; reload_en = 1'b1; dir = 1'b0; start = 1'b1;
        cyc("zero_load", 4'h0, ST_RUN, 1'b0);
        start = 1'b0;
        cyc("zero_done", 4'h0, ST_DN, 1'b1);
        repeat (3) cyc("zero_hold", 4'h0, ST_DN, 1'b0);

        // reset mid-run at count 2
        dir = 1'b1; interval = 4'h3; reload_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            start = (k == 0);
            cyc("rr_run", 4'h3, ST_RUN, 1'b0);
            start = 1'b0;
        end
        cyc("rr_two", 4'h2, ST_RUN, 1'b0);
        rst = 1'b1;
        cyc("rr_reset", 4'h0, ST_IDLE, 1'b0);
        rst = 1'b0;
        repeat (4) cyc("rr_after", 4'h0, ST_IDLE, 1'b0);

        // reset drops a pending timeout
        dir = 1'b1; interval = 4'h1; reload_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            start = (k == 0);
            cyc("rp_run", 4'h1, ST_RUN, 1'b0);
            start = 1'b0;
        end
        cyc("rp_term", 4'h0, ST_DN, 1'b0);
        rst = 1'b1;
        cyc("rp_reset", 4'h0, ST_IDLE, 1'b0);
        rst = 1'b0;
        repeat (3) cyc("rp_after", 4'h0, ST_IDLE, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/interval_timer_ctl.md
Name: interval_timer_ctl

Overview:
Next-generation interval timer with display for the whack-a-mole game. It has a prescaler that generates ticks and a programmable up/down interval counter of parameterised width. A run/pause/done control FSM supports optional auto-reload. The current count drives a hex seven-segment decoder, and the block raises a one-cycle timeout pulse that the game FSM uses to advance mole rounds.

Parameters:
TICK_DIV, 50000, clk cycles per tick; legal range ≥ 2; prescaler width is $clog2(TICK_DIV).
CNT_W, 4, width of interval and count; legal range 1..8.
SEG_ACT_LOW, 0, 1 inverts all seg outputs for common-anode displays.

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  reset, synchronous and active-high
start  in  1  one-cycle pulse: load and run (IDLE/DONE) or resume (PAUSE)
stop  in  1  one-cycle pulse: pause while RUN
clr  in  1  one-cycle pulse: abort to IDLE
dir  in  1  1 = count down interval→0; 0 = count up 0→interval; sampled only at load
reload_en  in  1  1 = auto-reload at terminal; sampled only at load
interval  in  CNT_W  terminal/start value; sampled only at load
count  out  CNT_W  current count
seg  out  7  {g,f,e,d,c,b,a}, hex decode of count[3:0], zero-extended when CNT_W<4
running  out  1  high in RUN
paused  out  1  high in PAUSE
done  out  1  high in DONE
timeout  out  1  registered one-cycle pulse when count reaches terminal

Behaviour:
- Reset (rst=1 at edge): state=IDLE, count=0, prescaler=0, timeout=0, running=paused=done=0, latched dir/reload/interval=0. seg then shows "0" (0x3F, or 0x40 with SEG_ACT_LOW=1).
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN; tick = (prescaler==TICK_DIV-1) in RUN, then the prescaler wraps to 0.
  - Holds its value in PAUSE.
  - Cleared on load, clr, and entry to IDLE/DONE.
- Load (start in IDLE or DONE): latch dir/reload_en/interval; count ← interval if dir=1, else 0; prescaler ← 0; state → RUN on the next edge.
  - If the latched interval == 0, then next cycle: state=DONE, timeout=1, reload ignored.
- RUN, on a tick with count ≠ terminal: count steps ±1. Terminal is 0 for down, the latched interval for up.
  - The step that makes count == terminal also sets timeout=1 for exactly the following cycle.
  - If reload=0, state → DONE on that same edge and count holds terminal.
  - If reload=1, stay in RUN; the next tick reloads count to the start value (no step). The terminal value is therefore visible for one full tick period.
- RUN + stop: → PAUSE. A tick on that same edge is discarded (count and prescaler unchanged).
- PAUSE + start: → RUN, prescaler resumes from its held value, no reload.
- DONE: count holds, done=1. start reloads with freshly sampled inputs.
- clr (any state): → IDLE, count=0, prescaler=0, timeout=0. clr has priority over stop, and stop over start, on the same edge.
- start while RUN: ignored. stop outside RUN: ignored.
- Mid-run changes to interval/dir/reload_en have no effect until the next load.
- rst mid-operation: same as reset, regardless of state; any timeout pulse pending is dropped.
- Output timing:
  - count and status outputs are registered.
  - seg is combinational from count (zero added latency).
  - timeout rises on the edge after the terminal step and falls one cycle later.
- No wrap-around: count never leaves the range 0..latched interval.
- Hex decode is standard: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71, inverted when SEG_ACT_LOW=1.

Test Plan:
- TICK_DIV=4, CNT_W=4: dir=1, interval=3, reload_en=0, start.
  - count 3→2→1→0, one step every 4 cycles.
  - timeout is high for 1 cycle, 1 cycle after count=0.
  - done=1 and count holds 0 indefinitely.
- dir=0, interval=5, reload_en=1.
  - count 0,1,...,5, then timeout pulse, 5 held for 4 cycles, then 0,1,... repeats.
  - Exactly one timeout per period of 24 cycles.
- Pause/resume:
  - stop issued 2 cycles after a step freezes count and prescaler for 10 cycles; paused=1.
  - start resumes and the next step occurs 2 cycles later.
  - A stop coinciding with a tick leaves count unchanged.
- Priority and ignored inputs:
  - start+stop+clr together in RUN → IDLE, count=0.
  - start+stop together in RUN → PAUSE.
  - start in RUN is ignored.
  - Changing interval mid-run does not alter the terminal value.
- interval=0 start → DONE on the next cycle with a single timeout pulse and count=0, even with reload_en=1.
- Reset mid-run at count=2:
  - All outputs return to reset values at the next edge (seg=0x3F); no timeout appears afterwards.
  - Repeat with SEG_ACT_LOW=1: seg=0x40.
